mem_arbiter: RTL and testbench

Shares the single-ported Memory block between the instruction-fetch (IF) and load/store (LS) requesters.
- Arbitrates one request per cycle and registers the selected command onto the Memory ports.
- Tags each in-flight access and routes the returned read data and error flags back to the originating requester.
- LS has priority; a starvation limit guarantees IF forward progress.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_arb_starve_ctr.sv | 37 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - mask encodings and command/tag types shared by the memory arbiter
package mem_pkg;

    localparam logic [1:0] WRMASK_N = 2'd0;
    localparam logic [1:0] WRMASK_B = 2'd1;
    localparam logic [1:0] WRMASK_H = 2'd2;
    localparam logic [1:0] WRMASK_W = 2'd3;

    localparam logic [2:0] RDMASK_W  = 3'd0;
    localparam logic [2:0] RDMASK_HZ = 3'd1;
    localparam logic [2:0] RDMASK_BZ = 3'd2;
    localparam logic [2:0] RDMASK_HE = 3'd3;
    localparam logic [2:0] RDMASK_BE = 3'd4;
    localparam logic [2:0] RDMASK_XX = 3'd5;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } mem_src_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [1:0]  wr_mask;
        logic [2:0]  rd_mask;
    } mem_cmd_t;

    typedef struct packed {
        logic     valid;
        mem_src_e src;
        logic     flushed;
    } mem_tag_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating IF starvation counter with force-IF compare
module mem_arb_starve_ctr
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CTR_W        = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_if_valid,
    input  logic i_if_grant,
    output logic o_force_if
);

    localparam logic [CTR_W-1:0] LIMIT = CTR_W'(STARVE_LIMIT);
    localparam logic [CTR_W-1:0] SAT   = {CTR_W{1'b1}};

    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (i_if_valid && !i_if_grant) begin
            cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + CTR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_force_if = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LS arbiter for the single-ported Memory, 2-cycle tagged responses
// Optional MEM_ARB_PERF_EN adds grant and IF-stall performance counters.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CTR_W        = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_valid,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_rsp_valid,
    output logic [31:0] o_if_rsp_data,
    input  logic        i_if_flush,
    input  logic        i_ls_valid,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wr_data,
    input  logic [1:0]  i_ls_wr_mask,
    input  logic [2:0]  i_ls_rd_mask,
    output logic        o_ls_ready,
    output logic        o_ls_rsp_valid,
    output logic [31:0] o_ls_rsp_data,
    output logic        o_ls_err_misaligned,
    output logic        o_ls_err_rd_mask,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wr_data,
    output logic [1:0]  o_mem_wr_mask,
    output logic [2:0]  o_mem_rd_mask,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_mem_err_misaligned,
    input  logic        i_mem_err_rd_mask
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] o_perf_if_grants,
    output logic [31:0] o_perf_ls_grants,
    output logic [31:0] o_perf_if_stall
`endif
);

    localparam mem_cmd_t CMD_IDLE = '{addr: 32'd0, wr_data: 32'd0,
                                      wr_mask: WRMASK_N, rd_mask: RDMASK_XX};

    mem_cmd_t cmd_q, cmd_d;
    mem_tag_t st1_q, st1_d, st2_q, st2_d;
    logic     force_if, if_grant, ls_grant;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CTR_W       (CTR_W)
    ) u_starve (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_if_valid(i_if_valid),
        .i_if_grant(if_grant),
        .o_force_if(force_if)
    );

    // Grants are gated by reset so no requester sees ready while the arbiter is held.
    always_comb begin
        ls_grant = i_reset & i_ls_valid & ~(force_if & i_if_valid);
        if_grant = i_reset & i_if_valid & ~ls_grant;
    end

    always_comb begin
        cmd_d         = cmd_q;
        cmd_d.wr_mask = WRMASK_N;
        cmd_d.rd_mask = RDMASK_XX;
        if (ls_grant) begin
            cmd_d.addr    = i_ls_addr;
            cmd_d.wr_data = i_ls_wr_data;
            cmd_d.wr_mask = i_ls_wr_mask;
            cmd_d.rd_mask = i_ls_rd_mask;
        end else if (if_grant) begin
            cmd_d.addr    = i_if_addr;
            cmd_d.rd_mask = RDMASK_W;
        end

        st1_d.valid   = ls_grant | if_grant;
        st1_d.src     = ls_grant ? SRC_LS : SRC_IF;
        st1_d.flushed = 1'b0;

        // Only the stage1 entry outlives this edge; stage2 is already presenting its response.
        st2_d = st1_q;
        if (i_if_flush && (st1_q.src == SRC_IF)) begin
            st2_d.flushed = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cmd_q <= CMD_IDLE;
            st1_q <= '0;
            st2_q <= '0;
        end else begin
            cmd_q <= cmd_d;
            st1_q <= st1_d;
            st2_q <= st2_d;
        end
    end

    assign o_if_ready    = if_grant;
    assign o_ls_ready    = ls_grant;
    assign o_mem_address = cmd_q.addr;
    assign o_mem_wr_data = cmd_q.wr_data;
    assign o_mem_wr_mask = cmd_q.wr_mask;
    assign o_mem_rd_mask = cmd_q.rd_mask;

    assign o_if_rsp_valid      = st2_q.valid & (st2_q.src == SRC_IF) & ~st2_q.flushed;
    assign o_ls_rsp_valid      = st2_q.valid & (st2_q.src == SRC_LS);
    assign o_if_rsp_data       = i_mem_rd_data;
    assign o_ls_rsp_data       = i_mem_rd_data;
    assign o_ls_err_misaligned = o_ls_rsp_valid & i_mem_err_misaligned;
    assign o_ls_err_rd_mask    = o_ls_rsp_valid & i_mem_err_rd_mask;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_ls_q, perf_stall_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            perf_if_q    <= '0;
            perf_ls_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (if_grant) perf_if_q <= perf_if_q + 32'd1;
            if (ls_grant) perf_ls_q <= perf_ls_q + 32'd1;
            if (i_if_valid && !if_grant) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign o_perf_if_grants = perf_if_q;
    assign o_perf_ls_grants = perf_ls_q;
    assign o_perf_if_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural Memory and scoreboard
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_if_valid, i_if_flush, i_ls_valid;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wr_data;
    logic [1:0]  i_ls_wr_mask;
    logic [2:0]  i_ls_rd_mask;
    logic        o_if_ready, o_if_rsp_valid, o_ls_ready, o_ls_rsp_valid;
    logic [31:0] o_if_rsp_data, o_ls_rsp_data;
    logic        o_ls_err_misaligned, o_ls_err_rd_mask;
    logic [31:0] o_mem_address, o_mem_wr_data;
    logic [1:0]  o_mem_wr_mask;
    logic [2:0]  o_mem_rd_mask;
    logic [31:0] mem_rd_data;
    logic        mem_err_mis, mem_err_rd;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if, perf_ls, perf_stall;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(STARVE), .CTR_W(4)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_if_valid(i_if_valid), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready),
        .o_if_rsp_valid(o_if_rsp_valid), .o_if_rsp_data(o_if_rsp_data), .i_if_flush(i_if_flush),
        .i_ls_valid(i_ls_valid), .i_ls_addr(i_ls_addr), .i_ls_wr_data(i_ls_wr_data),
        .i_ls_wr_mask(i_ls_wr_mask), .i_ls_rd_mask(i_ls_rd_mask), .o_ls_ready(o_ls_ready),
        .o_ls_rsp_valid(o_ls_rsp_valid), .o_ls_rsp_data(o_ls_rsp_data),
        .o_ls_err_misaligned(o_ls_err_misaligned), .o_ls_err_rd_mask(o_ls_err_rd_mask),
        .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
        .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
        .i_mem_rd_data(mem_rd_data), .i_mem_err_misaligned(mem_err_mis),
        .i_mem_err_rd_mask(mem_err_rd)
`ifdef MEM_ARB_PERF_EN
        , .o_perf_if_grants(perf_if), .o_perf_ls_grants(perf_ls), .o_perf_if_stall(perf_stall)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h41524A05 : (32'hC0DE0000 + 32'(i));
    endfunction

    function automatic logic misal(input logic [1:0] wm, input logic [31:0] a);
        return ((wm == WRMASK_H) && a[0]) || ((wm == WRMASK_W) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] wm, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (wm)
            WRMASK_B: r[8*off +: 8] = wd[7:0];
            WRMASK_H: r[16*off[1] +: 16] = wd[15:0];
            WRMASK_W: r = wd;
            default:  r = old;
        endcase
        return r;
    endfunction

    // Behavioural Memory: samples the command on each edge, answers one cycle later.
    logic [31:0] mem [64];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            mem_rd_data <= mem[o_mem_address[7:2]];
            mem_err_mis <= misal(o_mem_wr_mask, o_mem_address);
            mem_err_rd  <= (o_mem_rd_mask > RDMASK_XX);
            if (o_mem_wr_mask != WRMASK_N && !misal(o_mem_wr_mask, o_mem_address))
                mem[o_mem_address[7:2]] <= merge(mem[o_mem_address[7:2]], o_mem_wr_data,
                                                 o_mem_wr_mask, o_mem_address[1:0]);
        end
    end

    typedef struct packed {
        int          due;
        logic        is_if;
        logic        flushed;
        logic        chk_data;
        logic [31:0] data;
        logic        emis;
        logic        erd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] sb [64];
    int          cyc = 0;
    int          scnt = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          if_rsp_seen = 0;
    logic        last_if_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic if_v, input logic [31:0] if_a, input logic ls_v,
                        input logic [31:0] ls_a, input logic [31:0] wd, input logic [1:0] wm,
                        input logic [2:0] rm, input logic fl);
        exp_t e;
        logic has, eg_if, eg_ls, e_if_v, e_ls_v;
        @(negedge clk);
        i_if_valid = if_v; i_if_addr = if_a; i_if_flush = fl;
        i_ls_valid = ls_v; i_ls_addr = ls_a; i_ls_wr_data = wd;
        i_ls_wr_mask = wm; i_ls_rd_mask = rm;
        #1;
        eg_ls = ls_v && !(scnt >= STARVE && if_v);
        eg_if = if_v && !eg_ls;
        chk("if_ready", 32'(o_if_ready), 32'(eg_if));
        chk("ls_ready", 32'(o_ls_ready), 32'(eg_ls));
        last_if_ready = o_if_ready;

        e = '0;
        has = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            has = 1'b1;
        end
        e_if_v = has && e.is_if && !e.flushed;
        e_ls_v = has && !e.is_if;
        chk("if_rsp_valid", 32'(o_if_rsp_valid), 32'(e_if_v));
        chk("ls_rsp_valid", 32'(o_ls_rsp_valid), 32'(e_ls_v));
        if (o_if_rsp_valid) if_rsp_seen++;
        if (e_if_v) chk("if_rsp_data", o_if_rsp_data, e.data);
        if (e_ls_v && e.chk_data) chk("ls_rsp_data", o_ls_rsp_data, e.data);
        chk("ls_err_mis", 32'(o_ls_err_misaligned), 32'(e_ls_v && e.emis));
        chk("ls_err_rd", 32'(o_ls_err_rd_mask), 32'(e_ls_v && e.erd));

        // Effects of the coming edge on the reference model.
        if (fl) foreach (q[i]) if (q[i].is_if) q[i].flushed = 1'b1;
        if (eg_if) begin
            e = '0;
            e.due = cyc + 2; e.is_if = 1'b1; e.chk_data = 1'b1; e.data = sb[if_a[7:2]];
            q.push_back(e);
        end
        if (eg_ls) begin
            e = '0;
            e.due = cyc + 2; e.is_if = 1'b0;
            e.chk_data = (wm == WRMASK_N) && (rm == RDMASK_W);
            e.data = sb[ls_a[7:2]];
            e.emis = misal(wm, ls_a);
            e.erd = (rm > RDMASK_XX);
            q.push_back(e);
            if (wm != WRMASK_N && !misal(wm, ls_a))
                sb[ls_a[7:2]] = merge(sb[ls_a[7:2]], wd, wm, ls_a[1:0]);
        end
        scnt = (if_v && !eg_if) ? ((scnt < 15) ? scnt + 1 : 15) : 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, WRMASK_N, RDMASK_XX, 1'b0);
    endtask

    initial begin
        logic [9:0]  pat;
        int          seen0;
        logic        iv, lv, st, fl;
        logic [31:0] ia, la, wd;

        for (int i = 0; i < 64; i++) sb[i] = init_word(i);
        rst_n = 1'b0;
        i_if_valid = 1'b0; i_if_addr = '0; i_if_flush = 1'b0;
        i_ls_valid = 1'b0; i_ls_addr = '0; i_ls_wr_data = '0;
        i_ls_wr_mask = WRMASK_N; i_ls_rd_mask = RDMASK_XX;

        repeat (3) @(negedge clk);
        i_if_valid = 1'b1; i_ls_valid = 1'b1;
        #1;
        chk("rst_wr_mask", 32'(o_mem_wr_mask), 32'(WRMASK_N));
        chk("rst_rd_mask", 32'(o_mem_rd_mask), 32'(RDMASK_XX));
        chk("rst_addr", o_mem_address, 32'd0);
        chk("rst_wr_data", o_mem_wr_data, 32'd0);
        chk("rst_if_ready", 32'(o_if_ready), 32'd0);
        chk("rst_ls_ready", 32'(o_ls_ready), 32'd0);
        chk("rst_if_rsp", 32'(o_if_rsp_valid), 32'd0);
        chk("rst_ls_rsp", 32'(o_ls_rsp_valid), 32'd0);
        @(negedge clk);
        i_if_valid = 1'b0; i_ls_valid = 1'b0;
        rst_n = 1'b1;

        // IF-only read of the preloaded word.
        step(1'b1, 32'h10, 1'b0, 32'd0, 32'd0, WRMASK_N, RDMASK_XX, 1'b0);
        chk("if_read_ready", 32'(last_if_ready), 32'd1);
        idle(3);

        // Store then load to the same address, back to back.
        step(1'b0, 32'd0, 1'b1, 32'h40, 32'hDEADBEEF, WRMASK_W, RDMASK_XX, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'h40, 32'd0, WRMASK_N, RDMASK_W, 1'b0);
        idle(3);

        // Continuous contention: starvation limit forces an IF win every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h10 + 32'(4 * i), 1'b1, 32'h80 + 32'(4 * i), 32'd0,
                 WRMASK_N, RDMASK_W, 1'b0);
            pat[i] = last_if_ready;
        end
        chk("starve_pattern", 32'(pat), 32'(10'b1000010000));
        idle(3);

        // Flush: the earlier IF access is dropped, the one accepted with the flush responds.
        seen0 = if_rsp_seen;
        step(1'b1, 32'h10, 1'b0, 32'd0, 32'd0, WRMASK_N, RDMASK_XX, 1'b0);
        step(1'b1, 32'h14, 1'b0, 32'd0, 32'd0, WRMASK_N, RDMASK_XX, 1'b1);
        idle(3);
        chk("flush_rsp_count", 32'(if_rsp_seen - seen0), 32'd1);

        // Error reporting, then confirm the misaligned store left memory untouched.
        step(1'b0, 32'd0, 1'b1, 32'h41, 32'h00001234, WRMASK_H, RDMASK_XX, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'h40, 32'd0, WRMASK_N, 3'd6, 1'b0);
        step(1'b0, 32'd0, 1'b1, 32'h40, 32'd0, WRMASK_N, RDMASK_W, 1'b0);
        idle(3);

        // Reset while two accesses are in flight.
        step(1'b0, 32'd0, 1'b1, 32'h44, 32'h0BADF00D, WRMASK_W, RDMASK_XX, 1'b0);
        step(1'b1, 32'h18, 1'b0, 32'd0, 32'd0, WRMASK_N, RDMASK_XX, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        i_if_valid = 1'b1; i_ls_valid = 1'b1;
        #1;
        chk("mid_rst_wr_mask", 32'(o_mem_wr_mask), 32'(WRMASK_N));
        chk("mid_rst_rd_mask", 32'(o_mem_rd_mask), 32'(RDMASK_XX));
        chk("mid_rst_ls_rsp", 32'(o_ls_rsp_valid), 32'd0);
        chk("mid_rst_if_ready", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        i_if_valid = 1'b0; i_ls_valid = 1'b0;
        rst_n = 1'b1;
        q.delete();
        scnt = 0;
        idle(4);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            iv = ($urandom_range(0, 3) != 0);
            lv = ($urandom_range(0, 2) != 0);
            st = $urandom_range(0, 1) == 1;
            fl = ($urandom_range(0, 7) == 0);
            ia = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            la = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            wd = $urandom;
            if (st) step(iv, ia, lv, la, wd, WRMASK_W, RDMASK_XX, fl);
            else    step(iv, ia, lv, la, wd, WRMASK_N, RDMASK_W, fl);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
